// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: adds two WIDTH-bit operands one CHUNK-bit slice per cycle through an external ripple stage
module chunked_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] rca_in1,
  output logic [CHUNK-1:0] rca_in2,
  output logic             rca_cin,
  input  logic [CHUNK-1:0] rca_sum,
  input  logic             rca_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, r_ovf, r_valid, w_run, w_last;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_nxt;
  always_comb begin
    w_run = r_state == RUN;
    w_last = r_idx == IW'(NCH - 1);
    w_nxt = (r_state == IDLE && in_valid) ? RUN :
            (w_run && w_last) ? DONE :
            (r_state == DONE && out_ready) ? IDLE : r_state;
    in_ready = r_state == IDLE && !rst;
    rca_in1 = w_run ? r_a[r_idx*CHUNK +: CHUNK] : '0;
    rca_in2 = w_run ? r_b[r_idx*CHUNK +: CHUNK] : '0;
    rca_cin = w_run && r_carry;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
      r_carry <= cin;
      r_idx <= '0;
      r_sum <= '0;
    end else if (w_run) begin
      r_sum[r_idx*CHUNK +: CHUNK] <= rca_sum;
      r_carry <= rca_cout;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= rca_cout;
        r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (rca_sum[CHUNK-1] != r_a[WIDTH-1]);
        r_valid <= 1'b1;
      end
    end else if (r_state == DONE && out_ready)
      r_valid <= 1'b0;
  assign out_valid = r_valid;
  assign sum = r_sum;
  assign cout = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_chunked_adder_seq.sv
// tb_chunked_adder_seq: randomized and directed checks of chunked_adder_seq against an arithmetic reference
module tb_chunked_adder_seq;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;
  logic clk = 1'b0, rst, in_valid, in_ready, cin, rca_cin, rca_cout, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;
  logic [C-1:0] rca_in1, rca_in2, rca_sum;
  int n_chk = 0, n_fail = 0, cyc = 0, t_prev = 0;
  chunked_adder_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .rca_in1(rca_in1), .rca_in2(rca_in2), .rca_cin(rca_cin), .rca_sum(rca_sum), .rca_cout(rca_cout),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );
  assign {rca_cout, rca_sum} = {1'b0, rca_in1} + {1'b0, rca_in2} + {{C{1'b0}}, rca_cin};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit keep);
    int k = 0;
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    check("in_ready_wait", k < 40, 1);
    tick();
    in_valid = keep;
  endtask
  task automatic wait_res(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    logic [32:0] s;
    logic [63:0] lo, ci;
    int lat = 0;
    s = {1'b0, ta} + {1'b0, tb} + 33'(tc);
    while (!out_valid && lat < 40) begin
      if (lat < N) begin
        lo = (64'd1 << (C * lat)) - 64'd1;
        ci = ((64'(ta) & lo) + (64'(tb) & lo) + 64'(tc)) >> (C * lat);
        check("rca_cin", rca_cin, ci);
        check("rca_in1", rca_in1, (64'(ta) >> (C * lat)) & 64'hF);
        check("rca_in2", rca_in2, (64'(tb) >> (C * lat)) & 64'hF);
      end
      tick();
      lat++;
    end
    check("latency", lat, N);
    check("sum", sum, s[31:0]);
    check("cout", cout, s[32]);
    check("overflow", overflow, (ta[31] == tb[31]) && (s[31] != ta[31]));
    check("no_ready_in_done", in_ready, 0);
  endtask
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    start(ta, tb, tc, 1'b0);
    wait_res(ta, tb, tc);
    tick();
    check("back_idle_valid", out_valid, 0);
    check("back_idle_ready", in_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    op(32'h00000001, 32'h00000002, 1'b0);
    op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    op(32'h80000000, 32'h80000000, 1'b0);
    start(32'h0, 32'h0, 1'b1, 1'b0);
    wait_res(32'h0, 32'h0, 1'b1);
    out_ready = 1'b0;
    a = 32'h12345678;
    b = 32'h11111111;
    cin = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      check("stall_sum", sum, 1);
      check("stall_cout", cout, 0);
      check("stall_ovf", overflow, 0);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("unstall_valid", out_valid, 0);
    check("unstall_ready", in_ready, 1);
    check("unstall_sum_held", sum, 1);
    tick();
    in_valid = 1'b0;
    wait_res(32'h12345678, 32'h11111111, 1'b0);
    tick();
    start(32'hABCDEF01, 32'h12345678, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_rca_in1", rca_in1, 0);
    check("abort_rca_in2", rca_in2, 0);
    check("abort_rca_cin", rca_cin, 0);
    check("abort_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_ready", in_ready, 1);
    op(32'd5, 32'd7, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      start(ra, rb, rc, 1'b1);
      wait_res(ra, rb, rc);
      if (i > 0) check("throughput_gap", cyc - t_prev, N + 2);
      t_prev = cyc;
      tick();
    end
    in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
